// File: rtl/path_tester_pkg.sv
// Shared types and constants for the two-pattern path delay tester.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package path_tester_pkg;

    // Tester sequencing states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_PROPAGATE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // CCITT polynomial x^16+x^12+x^5+1, taps without the x^16 term
    localparam logic [15:0] MISR_POLY = 16'h1021;

    // Width of the transition-failure counter
    localparam int CNT_W = 16;

    // Counter value at which fail_count stops incrementing
    localparam logic [CNT_W-1:0] FAIL_SAT = {CNT_W{1'b1}};

    // Increment that sticks at FAIL_SAT instead of wrapping to zero
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == FAIL_SAT) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/path_tester_misr.sv
// Serial 16-bit LFSR compacting one response bit per shift.
// Latency: signature reflects a shifted bit on the cycle after the shift edge.
// Backpressure: none; shifts whenever shift is high, clr has priority.
module path_tester_misr
    import path_tester_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift,
    input  logic        din,
    output logic [15:0] sig
);

    // Galois-style feedback: the outgoing MSB xor the new bit selects the taps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (shift) begin
            sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ din) ? MISR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/path_delay_tester.sv
// Two-pattern transition tester for one sensitized path; signature LFSR under PATH_TESTER_MISR_EN.
// Latency: transition i launches at e0+i*(SETTLE+CAPTURE_DELAY)+SETTLE, captures CAPTURE_DELAY later.
// Backpressure: none; start is ignored while busy, accepted only in IDLE or DONE.
module path_delay_tester
    import path_tester_pkg::*;
#(
    parameter int SETTLE        = 8,
    parameter int CAPTURE_DELAY = 1,
    parameter int N_ROUNDS      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             path_inversion,
    input  logic             capture_in,
    output logic             launch_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic             static_err,
    output logic [15:0]      signature
);

    // Total transitions: each round is a rise followed by a fall
    localparam int T       = 2 * N_ROUNDS;
    localparam int TR_W    = $clog2(T + 1);
    localparam int TMR_MAX = (SETTLE > CAPTURE_DELAY) ? SETTLE : CAPTURE_DELAY;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   timer;
    logic [TR_W-1:0]    trans;
    logic               inv;

    logic               start_acc;
    logic               launch_evt;
    logic               capture_evt;
    logic               last_trans;
    logic               init_val;
    logic               launch_val;

    // Even transitions rise (0->1), odd transitions fall (1->0)
    assign init_val   = trans[0];
    assign launch_val = ~trans[0];
    assign last_trans = (trans == TR_W'(T - 1));

    // Next-state and phase events; each event marks the edge on which it takes effect
    always_comb begin
        state_nxt   = state;
        start_acc   = 1'b0;
        launch_evt  = 1'b0;
        capture_evt = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer == TMR_W'(SETTLE - 1)) begin
                    launch_evt = 1'b1;
                    state_nxt  = ST_PROPAGATE;
                end
            end
            ST_PROPAGATE: begin
                if (timer == TMR_W'(CAPTURE_DELAY - 1)) begin
                    capture_evt = 1'b1;
                    state_nxt   = last_trans ? ST_DONE : ST_SETTLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase timer: restarts on every phase boundary, counts within SETTLE/PROPAGATE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (start_acc || launch_evt || capture_evt) begin
            timer <= '0;
        end else if (state == ST_SETTLE || state == ST_PROPAGATE) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Transition index; the capture edge of one transition opens the next settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans <= '0;
        end else if (start_acc) begin
            trans <= '0;
        end else if (capture_evt && !last_trans) begin
            trans <= trans + TR_W'(1);
        end
    end

    // Path polarity is frozen for the whole run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv <= 1'b0;
        end else if (start_acc) begin
            inv <= path_inversion;
        end
    end

    // Path drive: init value at settle start, launch value at launch edge, 0 once finished
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            launch_out <= 1'b0;
        end else if (start_acc) begin
            launch_out <= 1'b0;
        end else if (launch_evt) begin
            launch_out <= launch_val;
        end else if (capture_evt) begin
            // Next init equals this launch value, so the line only moves at the end
            launch_out <= last_trans ? 1'b0 : launch_val;
        end
    end

    // Run status flags; done is a level held until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start_acc) begin
            busy <= 1'b1;
            done <= 1'b0;
        end else if (capture_evt && last_trans) begin
            busy <= 1'b0;
            done <= 1'b1;
        end
    end

    // Checkers: settled value on the launch edge, transitioned value on the capture edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_count <= '0;
            static_err <= 1'b0;
        end else if (start_acc) begin
            fail_count <= '0;
            static_err <= 1'b0;
        end else begin
            if (launch_evt && (capture_in != (init_val ^ inv))) begin
                static_err <= 1'b1;
            end
            if (capture_evt && (capture_in != (launch_val ^ inv))) begin
                fail_count <= sat_inc(fail_count);
            end
        end
    end

    assign pass = done && (fail_count == '0) && !static_err;

`ifdef PATH_TESTER_MISR_EN
    // Only transition captures are compacted; static samples are not
    path_tester_misr u_misr (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .shift (capture_evt),
        .din   (capture_in),
        .sig   (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_path_delay_tester.sv
module tb_path_delay_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance 1: default parameters, purely combinational path
    logic        start1 = 1'b0;
    logic        inv_sel1 = 1'b0;
    logic        phys_inv1 = 1'b0;
    logic        capture1;
    logic        launch1, busy1, done1, pass1, static1;
    logic [15:0] fail1, sig1;

    // Instance 2: CAPTURE_DELAY=2, path with k2 register stages
    logic        start2 = 1'b0;
    logic        inv_sel2 = 1'b0;
    logic        phys_inv2 = 1'b0;
    int          k2 = 0;
    logic [1:0]  pipe2 = 2'b00;
    logic        capture2;
    logic        launch2, busy2, done2, pass2, static2;
    logic [15:0] fail2, sig2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign capture1 = launch1 ^ phys_inv1;

    always @(posedge clk) pipe2 <= {pipe2[0], launch2 ^ phys_inv2};
    assign capture2 = (k2 == 0) ? (launch2 ^ phys_inv2) : ((k2 == 1) ? pipe2[0] : pipe2[1]);

    path_delay_tester dut1 (
        .clk(clk), .rst(rst), .start(start1), .path_inversion(inv_sel1),
        .capture_in(capture1), .launch_out(launch1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_count(fail1), .static_err(static1), .signature(sig1)
    );

    path_delay_tester #(.SETTLE(8), .CAPTURE_DELAY(2), .N_ROUNDS(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .path_inversion(inv_sel2),
        .capture_in(capture2), .launch_out(launch2), .busy(busy2), .done(done2),
        .pass(pass2), .fail_count(fail2), .static_err(static2), .signature(sig2)
    );

    // Pulse start1 so that the next rising edge is e0; returns at e0 + #1
    task automatic start_run1();
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    task automatic start_run2();
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
    endtask

    // Advance edge by edge until done1 is seen; cyc counts edges since e0
    task automatic wait_done1(input int from, output int cyc);
        cyc = from;
        while (done1 !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_done2(input int from, output int cyc);
        cyc = from;
        while (done2 !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (launch1 !== 1'b0)   begin n_bad++; $display("FAIL reset_launch got %b want 0", launch1); end
        n_cmp++; if (busy1 !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy1); end
        n_cmp++; if (done1 !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done1); end
        n_cmp++; if (pass1 !== 1'b0)     begin n_bad++; $display("FAIL reset_pass got %b want 0", pass1); end
        n_cmp++; if (fail1 !== 16'h0)    begin n_bad++; $display("FAIL reset_fail_count got %h want 0", fail1); end
        n_cmp++; if (static1 !== 1'b0)   begin n_bad++; $display("FAIL reset_static_err got %b want 0", static1); end
        n_cmp++; if (sig1 !== 16'h0)     begin n_bad++; $display("FAIL reset_signature got %h want 0", sig1); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (busy1 !== 1'b0)     begin n_bad++; $display("FAIL idle_no_start_busy got %b want 0", busy1); end
    endtask

    task automatic test_inv_comb();
        int cyc;
        phys_inv1 = 1'b1;
        inv_sel1  = 1'b1;
        start_run1();
        n_cmp++; if (busy1 !== 1'b1)   begin n_bad++; $display("FAIL e0_busy got %b want 1", busy1); end
        n_cmp++; if (launch1 !== 1'b0) begin n_bad++; $display("FAIL e0_launch got %b want 0", launch1); end
        repeat (7) @(posedge clk);
        #1;
        n_cmp++; if (launch1 !== 1'b0) begin n_bad++; $display("FAIL e7_launch got %b want 0", launch1); end
        @(posedge clk);
        #1;
        n_cmp++; if (launch1 !== 1'b1) begin n_bad++; $display("FAIL e8_launch got %b want 1", launch1); end
        wait_done1(8, cyc);
        n_cmp++; if (cyc != 72)        begin n_bad++; $display("FAIL inv_done_cycle got %0d want 72", cyc); end
        n_cmp++; if (fail1 !== 16'd0)  begin n_bad++; $display("FAIL inv_fail_count got %0d want 0", fail1); end
        n_cmp++; if (static1 !== 1'b0) begin n_bad++; $display("FAIL inv_static_err got %b want 0", static1); end
        n_cmp++; if (pass1 !== 1'b1)   begin n_bad++; $display("FAIL inv_pass got %b want 1", pass1); end
        n_cmp++; if (busy1 !== 1'b0)   begin n_bad++; $display("FAIL inv_busy_end got %b want 0", busy1); end
        n_cmp++; if (launch1 !== 1'b0) begin n_bad++; $display("FAIL inv_launch_end got %b want 0", launch1); end
    endtask

    task automatic test_static_err();
        int cyc;
        phys_inv1 = 1'b0;
        inv_sel1  = 1'b1;
        start_run1();
        repeat (7) @(posedge clk);
        #1;
        n_cmp++; if (static1 !== 1'b0) begin n_bad++; $display("FAIL st_e7_static got %b want 0", static1); end
        @(posedge clk);
        #1;
        n_cmp++; if (static1 !== 1'b1) begin n_bad++; $display("FAIL st_e8_static got %b want 1", static1); end
        n_cmp++; if (fail1 !== 16'd0)  begin n_bad++; $display("FAIL st_e8_fail got %0d want 0", fail1); end
        @(posedge clk);
        #1;
        n_cmp++; if (fail1 !== 16'd1)  begin n_bad++; $display("FAIL st_e9_fail got %0d want 1", fail1); end
        wait_done1(9, cyc);
        n_cmp++; if (cyc != 72)        begin n_bad++; $display("FAIL st_done_cycle got %0d want 72", cyc); end
        n_cmp++; if (fail1 !== 16'd8)  begin n_bad++; $display("FAIL st_fail_count got %0d want 8", fail1); end
        n_cmp++; if (pass1 !== 1'b0)   begin n_bad++; $display("FAIL st_pass got %b want 0", pass1); end
    endtask

    task automatic test_restart_from_done();
        int cyc;
        phys_inv1 = 1'b1;
        inv_sel1  = 1'b1;
        start_run1();
        n_cmp++; if (fail1 !== 16'd0)  begin n_bad++; $display("FAIL rs_fail_clear got %0d want 0", fail1); end
        n_cmp++; if (static1 !== 1'b0) begin n_bad++; $display("FAIL rs_static_clear got %b want 0", static1); end
        n_cmp++; if (done1 !== 1'b0)   begin n_bad++; $display("FAIL rs_done_clear got %b want 0", done1); end
        n_cmp++; if (sig1 !== 16'h0)   begin n_bad++; $display("FAIL rs_sig_clear got %h want 0", sig1); end
        wait_done1(0, cyc);
        n_cmp++; if (cyc != 72)        begin n_bad++; $display("FAIL rs_done_cycle got %0d want 72", cyc); end
        n_cmp++; if (pass1 !== 1'b1)   begin n_bad++; $display("FAIL rs_pass got %b want 1", pass1); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        phys_inv1 = 1'b1;
        inv_sel1  = 1'b1;
        start_run1();
        repeat (4) @(posedge clk);
        #1;
        start1   = 1'b1;
        inv_sel1 = 1'b0;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done1(5, cyc);
        n_cmp++; if (cyc != 72)      begin n_bad++; $display("FAIL ign_done_cycle got %0d want 72", cyc); end
        n_cmp++; if (pass1 !== 1'b1) begin n_bad++; $display("FAIL ign_pass got %b want 1", pass1); end
        inv_sel1 = 1'b1;
    endtask

    task automatic test_rst_mid();
        int cyc;
        phys_inv1 = 1'b0;
        inv_sel1  = 1'b1;
        start_run1();
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (static1 !== 1'b1) begin n_bad++; $display("FAIL mid_pre_static got %b want 1", static1); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy1 !== 1'b0)   begin n_bad++; $display("FAIL mid_busy got %b want 0", busy1); end
        n_cmp++; if (launch1 !== 1'b0) begin n_bad++; $display("FAIL mid_launch got %b want 0", launch1); end
        n_cmp++; if (static1 !== 1'b0) begin n_bad++; $display("FAIL mid_static got %b want 0", static1); end
        n_cmp++; if (fail1 !== 16'd0)  begin n_bad++; $display("FAIL mid_fail got %0d want 0", fail1); end
        n_cmp++; if (done1 !== 1'b0)   begin n_bad++; $display("FAIL mid_done got %b want 0", done1); end
        @(negedge clk);
        rst = 1'b0;
        phys_inv1 = 1'b1;
        start_run1();
        wait_done1(0, cyc);
        n_cmp++; if (cyc != 72)        begin n_bad++; $display("FAIL mid_rerun_cycle got %0d want 72", cyc); end
        n_cmp++; if (pass1 !== 1'b1)   begin n_bad++; $display("FAIL mid_rerun_pass got %b want 1", pass1); end
    endtask

    task automatic test_kstages();
        int cyc;
        phys_inv2 = 1'b0;
        inv_sel2  = 1'b0;
        k2 = 2;
        repeat (4) @(posedge clk);
        start_run2();
        wait_done2(0, cyc);
        n_cmp++; if (cyc != 80)        begin n_bad++; $display("FAIL k2_done_cycle got %0d want 80", cyc); end
        n_cmp++; if (fail2 !== 16'd8)  begin n_bad++; $display("FAIL k2_fail got %0d want 8", fail2); end
        n_cmp++; if (static2 !== 1'b0) begin n_bad++; $display("FAIL k2_static got %b want 0", static2); end
        n_cmp++; if (pass2 !== 1'b0)   begin n_bad++; $display("FAIL k2_pass got %b want 0", pass2); end
        k2 = 1;
        repeat (4) @(posedge clk);
        start_run2();
        wait_done2(0, cyc);
        n_cmp++; if (fail2 !== 16'd0)  begin n_bad++; $display("FAIL k1_fail got %0d want 0", fail2); end
        n_cmp++; if (pass2 !== 1'b1)   begin n_bad++; $display("FAIL k1_pass got %b want 1", pass2); end
    endtask

    task automatic test_misr();
        int cyc;
        logic [15:0] exp_sig;
        logic        b;
        phys_inv1 = 1'b0;
        inv_sel1  = 1'b0;
        start_run1();
        wait_done1(0, cyc);
        n_cmp++; if (pass1 !== 1'b1) begin n_bad++; $display("FAIL misr_pass got %b want 1", pass1); end
        exp_sig = 16'h0000;
`ifdef PATH_TESTER_MISR_EN
        for (int i = 0; i < 8; i++) begin
            b = (i % 2 == 0);
            exp_sig = {exp_sig[14:0], 1'b0} ^ ((exp_sig[15] ^ b) ? 16'h1021 : 16'h0000);
        end
`else
        b = 1'b0;
`endif
        n_cmp++; if (sig1 !== exp_sig) begin n_bad++; $display("FAIL misr_signature got %h want %h", sig1, exp_sig); end
    endtask

    initial begin
        test_reset();
        test_inv_comb();
        test_static_err();
        test_restart_from_done();
        test_start_ignored();
        test_rst_mid();
        test_kstages();
        test_misr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
